// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the two-master memory arbiter.
package mem_arbiter_pkg;

  // FSM state encodings
  localparam logic [1:0] ARB_IDLE  = 2'd0;
  localparam logic [1:0] ARB_CMD   = 2'd1;
  localparam logic [1:0] ARB_RWAIT = 2'd2;
  localparam logic [1:0] ARB_RRET  = 2'd3;

  // Captured operation encodings
  localparam logic ARB_OP_RD = 1'b0;
  localparam logic ARB_OP_WR = 1'b1;

  // Latency counter width; covers READ_LAT up to 15
  localparam int LAT_CNT_W = 4;

endpackage

// File: rtl/arb_rr2.sv
// Two-way round-robin pick. Purely combinational; the caller owns the
// last-grant pointer and decides when a grant may be issued.
module arb_rr2 (
  input  logic [1:0] req,
  input  logic       last,
  input  logic       enable,
  output logic [1:0] gnt,
  output logic       winner
);

  logic any_gnt;

  // Contention goes to the master not granted last; otherwise the lone requester
  always_comb begin
    winner = req[1];
    if (req == 2'b11) winner = ~last;
  end

  assign any_gnt = enable & (|req);
  assign gnt     = {winner, ~winner} & {2{any_gnt}};

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single-port memory between the CPU port (M0) and the loader (M1).
// One access in flight; registered memory command; fixed-latency read return.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int READ_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req_i,
  input  logic              m0_we_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [DATA_W-1:0] m0_wdata_i,
  output logic              m0_gnt_o,
  output logic              m0_rvalid_o,
  output logic [DATA_W-1:0] m0_rdata_o,
  input  logic              m1_req_i,
  input  logic              m1_we_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [DATA_W-1:0] m1_wdata_i,
  output logic              m1_gnt_o,
  output logic              m1_rvalid_o,
  output logic [DATA_W-1:0] m1_rdata_o,
  output logic              memread_o,
  output logic              memwrite_o,
  output logic [ADDR_W-1:0] memaddr_o,
  output logic [DATA_W-1:0] memwdata_o,
  input  logic [DATA_W-1:0] memrdata_i,
  output logic              busy_o
);

  localparam logic [LAT_CNT_W-1:0] LAT_INIT = LAT_CNT_W'(READ_LAT - 1);

  logic [1:0]              state;
  logic                    last;
  logic                    owner;
  logic                    op;
  logic [LAT_CNT_W-1:0]    lat_cnt;
  logic [1:0][DATA_W-1:0]  rdata_q;

  logic [1:0]              req;
  logic [1:0]              gnt;
  logic                    winner;
  logic                    arb_en;
  logic                    gnt_any;
  logic                    sel_we;
  logic [ADDR_W-1:0]       sel_addr;
  logic [DATA_W-1:0]       sel_wdata;

  // Grants only open in IDLE/RRET; gated by reset so nothing leaks out while held
  assign req    = {m1_req_i, m0_req_i};
  assign arb_en = rst & ((state == ARB_IDLE) | (state == ARB_RRET));

  arb_rr2 u_rr (
    .req    (req),
    .last   (last),
    .enable (arb_en),
    .gnt    (gnt),
    .winner (winner)
  );

  assign gnt_any   = |gnt;
  assign sel_we    = winner ? m1_we_i    : m0_we_i;
  assign sel_addr  = winner ? m1_addr_i  : m0_addr_i;
  assign sel_wdata = winner ? m1_wdata_i : m0_wdata_i;

  // Command register: strobes live for exactly the CMD cycle, addr/data hold
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      memread_o  <= 1'b0;
      memwrite_o <= 1'b0;
      memaddr_o  <= '0;
      memwdata_o <= '0;
      op         <= ARB_OP_RD;
      owner      <= 1'b0;
      last       <= 1'b1;
    end else begin
      memread_o  <= gnt_any & (sel_we == ARB_OP_RD);
      memwrite_o <= gnt_any & (sel_we == ARB_OP_WR);
      if (gnt_any) begin
        memaddr_o  <= sel_addr;
        memwdata_o <= sel_wdata;
        op         <= sel_we;
        owner      <= winner;
        last       <= winner;
      end
    end
  end

  // FSM, read-latency counter and per-master read data capture
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ARB_IDLE;
      lat_cnt <= '0;
      rdata_q <= '0;
    end else begin
      case (state)
        ARB_IDLE, ARB_RRET: state <= gnt_any ? ARB_CMD : ARB_IDLE;
        ARB_CMD: begin
          if (op == ARB_OP_WR) begin
            state <= ARB_IDLE;
          end else begin
            lat_cnt <= LAT_INIT;
            if (READ_LAT > 1) begin
              state <= ARB_RWAIT;
            end else begin
              state          <= ARB_RRET;
              rdata_q[owner] <= memrdata_i;
            end
          end
        end
        default: begin
          // RWAIT: the edge that takes the counter to zero samples memory
          lat_cnt <= lat_cnt - 1'b1;
          if (lat_cnt == LAT_CNT_W'(1)) begin
            state          <= ARB_RRET;
            rdata_q[owner] <= memrdata_i;
          end
        end
      endcase
    end
  end

  assign m0_gnt_o    = gnt[0];
  assign m1_gnt_o    = gnt[1];
  assign m0_rvalid_o = (state == ARB_RRET) & ~owner;
  assign m1_rvalid_o = (state == ARB_RRET) &  owner;
  assign m0_rdata_o  = rdata_q[0];
  assign m1_rdata_o  = rdata_q[1];
  assign busy_o      = (state != ARB_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: dut a uses READ_LAT=1, dut b READ_LAT=3.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // dut a signals (READ_LAT=1)
  logic        a_m0_req = 0, a_m0_we = 0, a_m1_req = 0, a_m1_we = 0;
  logic [31:0] a_m0_addr = 0, a_m0_wdata = 0, a_m1_addr = 0, a_m1_wdata = 0;
  logic        a_m0_gnt, a_m0_rvalid, a_m1_gnt, a_m1_rvalid;
  logic [31:0] a_m0_rdata, a_m1_rdata;
  logic        a_memread, a_memwrite, a_busy;
  logic [31:0] a_memaddr, a_memwdata, a_memrdata;

  // dut b signals (READ_LAT=3)
  logic        b_m0_req = 0, b_m0_we = 0, b_m1_req = 0, b_m1_we = 0;
  logic [31:0] b_m0_addr = 0, b_m0_wdata = 0, b_m1_addr = 0, b_m1_wdata = 0;
  logic        b_m0_gnt, b_m0_rvalid, b_m1_gnt, b_m1_rvalid;
  logic [31:0] b_m0_rdata, b_m1_rdata;
  logic        b_memread, b_memwrite, b_busy;
  logic [31:0] b_memaddr, b_memwdata, b_memrdata;
  logic [1:0]  b_pipe = 2'b00;

  int nv = 0;
  int nf = 0;

  // Memory models: data valid only in the cycle the arbiter should sample it
  assign a_memrdata = a_memread ? 32'hDEADBEEF : 32'h0;
  always @(posedge clk) b_pipe <= {b_pipe[0], b_memread};
  assign b_memrdata = b_pipe[1] ? 32'hCAFEF00D : 32'h0;

  mem_arbiter #(.DATA_W(32), .ADDR_W(32), .READ_LAT(1)) dut_a (
    .clk(clk), .rst(rst),
    .m0_req_i(a_m0_req), .m0_we_i(a_m0_we), .m0_addr_i(a_m0_addr), .m0_wdata_i(a_m0_wdata),
    .m0_gnt_o(a_m0_gnt), .m0_rvalid_o(a_m0_rvalid), .m0_rdata_o(a_m0_rdata),
    .m1_req_i(a_m1_req), .m1_we_i(a_m1_we), .m1_addr_i(a_m1_addr), .m1_wdata_i(a_m1_wdata),
    .m1_gnt_o(a_m1_gnt), .m1_rvalid_o(a_m1_rvalid), .m1_rdata_o(a_m1_rdata),
    .memread_o(a_memread), .memwrite_o(a_memwrite), .memaddr_o(a_memaddr),
    .memwdata_o(a_memwdata), .memrdata_i(a_memrdata), .busy_o(a_busy)
  );

  mem_arbiter #(.DATA_W(32), .ADDR_W(32), .READ_LAT(3)) dut_b (
    .clk(clk), .rst(rst),
    .m0_req_i(b_m0_req), .m0_we_i(b_m0_we), .m0_addr_i(b_m0_addr), .m0_wdata_i(b_m0_wdata),
    .m0_gnt_o(b_m0_gnt), .m0_rvalid_o(b_m0_rvalid), .m0_rdata_o(b_m0_rdata),
    .m1_req_i(b_m1_req), .m1_we_i(b_m1_we), .m1_addr_i(b_m1_addr), .m1_wdata_i(b_m1_wdata),
    .m1_gnt_o(b_m1_gnt), .m1_rvalid_o(b_m1_rvalid), .m1_rdata_o(b_m1_rdata),
    .memread_o(b_memread), .memwrite_o(b_memwrite), .memaddr_o(b_memaddr),
    .memwdata_o(b_memwdata), .memrdata_i(b_memrdata), .busy_o(b_busy)
  );

  // Advance to just after the next rising edge (start of next cycle)
  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic test_reset_state();
    rst = 1'b0; a_m0_req = 1'b1; b_m1_req = 1'b1;
    #2;
    nv++; if ({a_m0_gnt, a_m1_gnt, a_memread, a_memwrite, a_busy, a_m0_rvalid, a_m1_rvalid} !== 7'b0) begin
      nf++; $display("FAIL rst_a_ctl: got %b want 0000000", {a_m0_gnt, a_m1_gnt, a_memread, a_memwrite, a_busy, a_m0_rvalid, a_m1_rvalid}); end
    nv++; if ({b_m0_gnt, b_m1_gnt, b_memread, b_memwrite, b_busy, b_m0_rvalid, b_m1_rvalid} !== 7'b0) begin
      nf++; $display("FAIL rst_b_ctl: got %b want 0000000", {b_m0_gnt, b_m1_gnt, b_memread, b_memwrite, b_busy, b_m0_rvalid, b_m1_rvalid}); end
    nv++; if ({a_memaddr, a_memwdata, a_m0_rdata, a_m1_rdata} !== 128'h0) begin
      nf++; $display("FAIL rst_a_data: got %h want 0", {a_memaddr, a_memwdata, a_m0_rdata, a_m1_rdata}); end
    a_m0_req = 1'b0; b_m1_req = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
  endtask

  task automatic test_m0_read();
    a_m0_req = 1'b1; a_m0_we = 1'b0; a_m0_addr = 32'h10;
    @(negedge clk);
    nv++; if ({a_m1_gnt, a_m0_gnt} !== 2'b01) begin
      nf++; $display("FAIL rd_gnt: got %b want 01", {a_m1_gnt, a_m0_gnt}); end
    cyc(); a_m0_req = 1'b0;
    @(negedge clk);
    nv++; if ({a_memread, a_memwrite, a_busy, a_memaddr} !== {3'b101, 32'h10}) begin
      nf++; $display("FAIL rd_cmd: got %b/%h want 101/00000010", {a_memread, a_memwrite, a_busy}, a_memaddr); end
    cyc(); @(negedge clk);
    nv++; if ({a_m0_rvalid, a_m1_rvalid, a_m0_rdata} !== {2'b10, 32'hDEADBEEF}) begin
      nf++; $display("FAIL rd_ret: got %b/%h want 10/deadbeef", {a_m0_rvalid, a_m1_rvalid}, a_m0_rdata); end
    cyc(); @(negedge clk);
    nv++; if ({a_m0_rvalid, a_busy, a_m0_rdata} !== {2'b00, 32'hDEADBEEF}) begin
      nf++; $display("FAIL rd_hold: got %b/%h want 00/deadbeef", {a_m0_rvalid, a_busy}, a_m0_rdata); end
    cyc();
  endtask

  task automatic test_m1_write();
    a_m1_req = 1'b1; a_m1_we = 1'b1; a_m1_addr = 32'h20; a_m1_wdata = 32'h12345678;
    @(negedge clk);
    nv++; if ({a_m1_gnt, a_m0_gnt} !== 2'b10) begin
      nf++; $display("FAIL wr_gnt: got %b want 10", {a_m1_gnt, a_m0_gnt}); end
    cyc(); a_m1_req = 1'b0;
    @(negedge clk);
    nv++; if ({a_memwrite, a_memread, a_memaddr, a_memwdata} !== {2'b10, 32'h20, 32'h12345678}) begin
      nf++; $display("FAIL wr_cmd: got %b/%h/%h want 10/00000020/12345678", {a_memwrite, a_memread}, a_memaddr, a_memwdata); end
    cyc(); @(negedge clk);
    nv++; if ({a_busy, a_memwrite, a_m1_rvalid} !== 3'b000) begin
      nf++; $display("FAIL wr_done: got %b want 000", {a_busy, a_memwrite, a_m1_rvalid}); end
    cyc();
  endtask

  task automatic test_alternate();
    do_reset();
    a_m0_req = 1'b1; a_m0_we = 1'b1; a_m0_addr = 32'h100; a_m0_wdata = 32'hA0;
    a_m1_req = 1'b1; a_m1_we = 1'b1; a_m1_addr = 32'h200; a_m1_wdata = 32'hB1;
    for (int c = 0; c < 8; c++) begin
      logic [1:0] exp;
      exp = (c % 4 == 0) ? 2'b01 : (c % 4 == 2) ? 2'b10 : 2'b00;
      @(negedge clk);
      nv++; if ({a_m1_gnt, a_m0_gnt} !== exp) begin
        nf++; $display("FAIL alt_gnt c%0d: got %b want %b", c, {a_m1_gnt, a_m0_gnt}, exp); end
      cyc();
    end
    a_m0_req = 1'b0; a_m1_req = 1'b0;
    cyc();
  endtask

  task automatic test_lat3();
    do_reset();
    b_m0_req = 1'b1; b_m0_we = 1'b0; b_m0_addr = 32'h30;
    b_m1_req = 1'b1; b_m1_we = 1'b1; b_m1_addr = 32'h44; b_m1_wdata = 32'h55AA;
    @(negedge clk);
    nv++; if ({b_m1_gnt, b_m0_gnt} !== 2'b01) begin
      nf++; $display("FAIL l3_gnt0: got %b want 01", {b_m1_gnt, b_m0_gnt}); end
    cyc(); b_m0_req = 1'b0;
    @(negedge clk);
    nv++; if ({b_memread, b_m1_gnt, b_memaddr} !== {2'b10, 32'h30}) begin
      nf++; $display("FAIL l3_cmd: got %b/%h want 10/00000030", {b_memread, b_m1_gnt}, b_memaddr); end
    for (int c = 2; c < 4; c++) begin
      cyc(); @(negedge clk);
      nv++; if ({b_m1_gnt, b_m0_rvalid, b_busy} !== 3'b001) begin
        nf++; $display("FAIL l3_wait c%0d: got %b want 001", c, {b_m1_gnt, b_m0_rvalid, b_busy}); end
    end
    cyc(); @(negedge clk);
    nv++; if ({b_m0_rvalid, b_m1_gnt, b_m0_rdata} !== {2'b11, 32'hCAFEF00D}) begin
      nf++; $display("FAIL l3_ret: got %b/%h want 11/cafef00d", {b_m0_rvalid, b_m1_gnt}, b_m0_rdata); end
    cyc(); b_m1_req = 1'b0;
    @(negedge clk);
    nv++; if ({b_memwrite, b_memread, b_m0_rvalid, b_memaddr, b_memwdata} !== {3'b100, 32'h44, 32'h55AA}) begin
      nf++; $display("FAIL l3_m1cmd: got %b/%h/%h want 100/00000044/000055aa", {b_memwrite, b_memread, b_m0_rvalid}, b_memaddr, b_memwdata); end
    cyc(); cyc();
  endtask

  task automatic test_req_drop();
    a_m0_req = 1'b1; a_m0_we = 1'b1; a_m0_addr = 32'h50; a_m0_wdata = 32'h5;
    @(negedge clk);
    nv++; if ({a_m1_gnt, a_m0_gnt} !== 2'b01) begin
      nf++; $display("FAIL drop_gnt0: got %b want 01", {a_m1_gnt, a_m0_gnt}); end
    cyc(); a_m0_req = 1'b0;
    a_m1_req = 1'b1; a_m1_we = 1'b0; a_m1_addr = 32'h60;
    @(negedge clk);
    nv++; if ({a_m1_gnt, a_memwrite, a_memread} !== 3'b010) begin
      nf++; $display("FAIL drop_cmd: got %b want 010", {a_m1_gnt, a_memwrite, a_memread}); end
    cyc(); a_m1_req = 1'b0;
    for (int c = 2; c < 5; c++) begin
      @(negedge clk);
      nv++; if ({a_m1_gnt, a_memread, a_memwrite, a_m1_rvalid} !== 4'b0000) begin
        nf++; $display("FAIL drop_idle c%0d: got %b want 0000", c, {a_m1_gnt, a_memread, a_memwrite, a_m1_rvalid}); end
      cyc();
    end
  endtask

  task automatic test_reset_mid();
    b_m0_req = 1'b1; b_m0_we = 1'b0; b_m0_addr = 32'h70;
    cyc(); b_m0_req = 1'b0;
    a_m0_req = 1'b1; a_m0_we = 1'b0; a_m0_addr = 32'h80;
    cyc(); a_m0_req = 1'b0;
    b_m1_req = 1'b1; b_m1_we = 1'b1;
    // dut b is in RWAIT, dut a in CMD with memread high
    nv++; if ({a_memread, b_busy} !== 2'b11) begin
      nf++; $display("FAIL rstm_pre: got %b want 11", {a_memread, b_busy}); end
    rst = 1'b0; #1;
    nv++; if ({a_memread, a_busy, b_busy, b_m0_rvalid, b_m1_gnt, b_memread} !== 6'b0) begin
      nf++; $display("FAIL rstm_now: got %b want 000000", {a_memread, a_busy, b_busy, b_m0_rvalid, b_m1_gnt, b_memread}); end
    b_m1_req = 1'b0;
    cyc(); rst = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      nv++; if ({b_m0_rvalid, b_busy, a_m0_rvalid, a_busy} !== 4'b0000) begin
        nf++; $display("FAIL rstm_after c%0d: got %b want 0000", c, {b_m0_rvalid, b_busy, a_m0_rvalid, a_busy}); end
      cyc();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    test_reset_state();
    test_m0_read();
    test_m1_write();
    test_alternate();
    test_lat3();
    test_req_drop();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nv, nf);
    $finish;
  end

endmodule
